// File: rtl/fir_stream_driver.sv
// fir_stream_driver: buffers upstream samples in a small FIFO and feeds them one at a time to a FIR controller, forwarding each result downstream
module fir_stream_driver #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 38,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              fir_in_valid,
    output logic [DATA_W-1:0] fir_in_data,
    input  logic              fir_out_valid,
    input  logic [OUT_W-1:0]  fir_out_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              busy,
    output logic              timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [CW-1:0] wait_cnt;
    logic push, pop, issue, capture, expire;

    assign s_ready = (count != FULL);
    assign push    = s_valid && s_ready;
    assign pop     = (state == ISSUE);
    assign issue   = (state == IDLE) && (state_nxt == ISSUE);
    assign capture = (state == WAIT) && fir_out_valid;
    assign expire  = (state == WAIT) && !fir_out_valid && (wait_cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: issue only when the output slot is free or being freed, so a result can always be captured
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0 && (!m_valid || m_ready)) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fir_out_valid || wait_cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe outputs decoded from the current state
    always_comb begin
        fir_in_valid = (state == ISSUE);
        busy         = (state == WAIT);
    end

    // Sample storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // FIFO bookkeeping, issued sample, result register, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fir_in_data <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (issue) fir_in_data <= mem[rd_ptr];
            if (capture) begin
                m_valid <= 1'b1;
                m_data  <= fir_out_data;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            wait_cnt <= (state == WAIT && state_nxt == WAIT) ? wait_cnt + CW'(1) : '0;
            if (expire) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_stream_driver.sv
// tb_fir_stream_driver: directed and randomized checks against a queue-based model of the result stream
module tb_fir_stream_driver;
    localparam int DW = 16;
    localparam int OW = 38;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          fir_in_valid;
    logic [DW-1:0] fir_in_data;
    logic          fir_out_valid = 1'b0;
    logic [OW-1:0] fir_out_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [OW-1:0] m_data;
    logic          busy;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;

    int            fir_delay = 10;
    bit            fixed_en = 1'b0;
    logic [OW-1:0] fixed_val = '0;
    bit            spur_req = 1'b0;
    int            resp_cnt = -1;
    logic [DW-1:0] resp_sample = '0;

    logic [DW-1:0] pushed[$];
    logic [DW-1:0] issued[$];
    logic [OW-1:0] got[$];
    bit            prev_hold = 1'b0;
    logic [OW-1:0] prev_md = '0;

    always #5 clk = ~clk;

    fir_stream_driver dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_in_valid(fir_in_valid), .fir_in_data(fir_in_data),
        .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [OW-1:0] fir_model(input logic [DW-1:0] s);
        return OW'(s) * OW'(40503) + OW'(17);
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!fir_in_valid && n < 300) begin
            step();
            n++;
        end
        check(tag, OW'(fir_in_valid), OW'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        pushed.delete();
        issued.delete();
        got.delete();
        step();
    endtask

    // FIR controller stand-in: answers fir_delay cycles after each start pulse
    always @(negedge clk) begin
        fir_out_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                fir_out_valid = 1'b1;
                fir_out_data  = fixed_en ? fixed_val : fir_model(resp_sample);
                resp_cnt      = -1;
            end
        end
        if (spur_req) begin
            fir_out_valid = 1'b1;
            fir_out_data  = fir_model(16'h5555);
        end
        if (fir_in_valid && !rst) begin
            check("one_in_flight", OW'(resp_cnt > 0), OW'(0));
            resp_sample = fir_in_data;
            resp_cnt    = (fir_delay >= 1) ? fir_delay : -1;
        end
    end

    // Transfer monitor and downstream hold check
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) pushed.push_back(s_data);
            if (fir_in_valid) issued.push_back(fir_in_data);
            if (prev_hold) begin
                check("hold_valid", OW'(m_valid), OW'(1));
                check("hold_data", m_data, prev_md);
            end
            if (m_valid && m_ready) got.push_back(m_data);
            prev_hold = m_valid && !m_ready;
            prev_md   = m_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        int n;
        step(3);
        check("rst_fir_in_valid", OW'(fir_in_valid), OW'(0));
        check("rst_fir_in_data", OW'(fir_in_data), OW'(0));
        check("rst_m_valid", OW'(m_valid), OW'(0));
        check("rst_m_data", m_data, OW'(0));
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_timeout_err", OW'(timeout_err), OW'(0));
        rst = 1'b0;
        step();
        check("rst_s_ready", OW'(s_ready), OW'(1));

        // single sample with a fixed FIR answer after 66 cycles
        fixed_en = 1'b1;
        fixed_val = 38'hABCD;
        fir_delay = 66;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 16'h0012;
        step();
        s_valid = 1'b0;
        check("t1_no_issue_yet", OW'(fir_in_valid), OW'(0));
        step();
        check("t1_issue", OW'(fir_in_valid), OW'(1));
        check("t1_issue_data", OW'(fir_in_data), OW'(16'h0012));
        step();
        check("t1_pulse_once", OW'(fir_in_valid), OW'(0));
        check("t1_busy", OW'(busy), OW'(1));
        n = 1;
        while (!m_valid && n < 200) begin
            step();
            n++;
        end
        check("t1_latency", OW'(n), OW'(67));
        check("t1_m_data", m_data, 38'hABCD);
        step();
        check("t1_m_valid_clear", OW'(m_valid), OW'(0));
        check("t1_issue_count", OW'(issued.size()), OW'(1));
        check("t1_got_count", OW'(got.size()), OW'(1));
        check("t1_hold_data", OW'(fir_in_data), OW'(16'h0012));

        // fill and backpressure
        do_reset();
        fixed_en = 1'b0;
        fir_delay = 5;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = DW'($urandom);
            n = 0;
            while (!s_ready && n < 100) begin
                step();
                n++;
            end
            step();
        end
        s_valid = 1'b0;
        check("t2_full", OW'(s_ready), OW'(0));
        step(30);
        check("t2_still_full", OW'(s_ready), OW'(0));
        check("t2_pushed", OW'(pushed.size()), OW'(5));
        check("t2_one_issued", OW'(issued.size()), OW'(1));
        check("t2_m_valid", OW'(m_valid), OW'(1));
        if (pushed.size() > 0) check("t2_m_data", m_data, fir_model(pushed[0]));
        m_ready = 1'b1;
        n = 0;
        while (got.size() < 5 && n < 1000) begin
            step();
            n++;
        end
        check("t2_got_count", OW'(got.size()), OW'(5));
        for (int i = 0; i < 5 && i < got.size() && i < pushed.size(); i++)
            check("t2_order", got[i], fir_model(pushed[i]));
        check("t2_s_ready_end", OW'(s_ready), OW'(1));

        // timeout: first sample never answered, second one is
        do_reset();
        fir_delay = -1;
        s_valid = 1'b1;
        s_data = 16'h1111;
        step();
        s_data = 16'h2222;
        step();
        s_valid = 1'b0;
        wait_issue("t3_issue_x");
        check("t3_issue_x_data", OW'(fir_in_data), OW'(16'h1111));
        step(100);
        check("t3_no_err_yet", OW'(timeout_err), OW'(0));
        check("t3_busy_last", OW'(busy), OW'(1));
        fir_delay = 10;
        step();
        check("t3_err", OW'(timeout_err), OW'(1));
        check("t3_idle", OW'(busy), OW'(0));
        step();
        check("t3_issue_y", OW'(fir_in_valid), OW'(1));
        check("t3_issue_y_data", OW'(fir_in_data), OW'(16'h2222));
        step(20);
        check("t3_got_count", OW'(got.size()), OW'(1));
        if (got.size() > 0) check("t3_got_y", got[0], fir_model(16'h2222));
        check("t3_err_sticky", OW'(timeout_err), OW'(1));

        // result on the last wait cycle wins; one cycle later is a timeout
        do_reset();
        check("t4_err_cleared", OW'(timeout_err), OW'(0));
        fir_delay = TO;
        s_valid = 1'b1;
        s_data = 16'h0BAD;
        step();
        s_valid = 1'b0;
        wait_issue("t4_issue");
        step(100);
        check("t4_busy_last", OW'(busy), OW'(1));
        step();
        check("t4_m_valid", OW'(m_valid), OW'(1));
        check("t4_m_data", m_data, fir_model(16'h0BAD));
        check("t4_no_err", OW'(timeout_err), OW'(0));
        fir_delay = TO + 1;
        s_valid = 1'b1;
        s_data = 16'h0CAB;
        step();
        s_valid = 1'b0;
        wait_issue("t4b_issue");
        step(101);
        check("t4b_err", OW'(timeout_err), OW'(1));
        check("t4b_idle", OW'(busy), OW'(0));
        step(3);
        check("t4b_late_ignored", OW'(m_valid), OW'(0));
        check("t4b_got_count", OW'(got.size()), OW'(1));

        // reset in the middle of a wait, FIR answers after release
        do_reset();
        fir_delay = 20;
        s_valid = 1'b1;
        s_data = 16'h0777;
        step();
        s_valid = 1'b0;
        wait_issue("t5_issue");
        step(11);
        check("t5_busy_before", OW'(busy), OW'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_busy", OW'(busy), OW'(0));
        check("t5_rst_fir_in_data", OW'(fir_in_data), OW'(0));
        check("t5_rst_fir_in_valid", OW'(fir_in_valid), OW'(0));
        step(2);
        rst = 1'b0;
        step(15);
        check("t5_no_m_valid", OW'(m_valid), OW'(0));
        check("t5_m_data", m_data, OW'(0));
        check("t5_busy", OW'(busy), OW'(0));
        check("t5_s_ready", OW'(s_ready), OW'(1));
        check("t5_got_count", OW'(got.size()), OW'(0));
        check("t5_err", OW'(timeout_err), OW'(0));

        // spurious FIR pulse while idle and empty
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        step(3);
        check("t6_m_valid", OW'(m_valid), OW'(0));
        check("t6_m_data", m_data, OW'(0));
        check("t6_busy", OW'(busy), OW'(0));
        check("t6_fir_in_valid", OW'(fir_in_valid), OW'(0));
        check("t6_s_ready", OW'(s_ready), OW'(1));

        // randomized traffic: every pushed sample comes out once, in order
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data = DW'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            fir_delay = int'($urandom_range(1, 90));
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (got.size() < pushed.size() && n < 3000) begin
            step();
            n++;
        end
        step(3);
        check("t7_enough_traffic", OW'(pushed.size() > 10), OW'(1));
        check("t7_count", OW'(got.size()), OW'(pushed.size()));
        for (int i = 0; i < got.size() && i < pushed.size(); i++)
            check("t7_order", got[i], fir_model(pushed[i]));
        check("t7_no_err", OW'(timeout_err), OW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_stream_driver.md
FIR_STREAM_DRIVER -- requirements
Module: fir_stream_driver

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, sample width.
- OUT_W, default 38, FIR result width.
- FIFO_DEPTH, default 4, sample buffer depth (power of 2, >=2).
- TIMEOUT, default 100, maximum cycles to wait for a FIR result.
REQ-002 Ports SHALL be:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  upstream may transfer.
- s_data  input  DATA_W  upstream sample.
- fir_in_valid  output  1  one-cycle start pulse to the FIR controller's inputValid.
- fir_in_data  output  DATA_W  sample presented to the FIR datapath.
- fir_out_valid  input  1  FIR controller's outputValid pulse.
- fir_out_data  input  OUT_W  FIR result, valid when fir_out_valid=1.
- m_valid  output  1  downstream result valid.
- m_ready  input  1  downstream accepts.
- m_data  output  OUT_W  downstream result.
- busy  output  1  a sample is in flight in the FIR.
- timeout_err  output  1  sticky; a FIR result failed to arrive.

Function
REQ-003 Upstream transfer SHALL occur on a rising edge with s_valid=1 and s_ready=1; the sample SHALL be written to the FIFO tail.
REQ-004 s_ready SHALL equal (FIFO count != FIFO_DEPTH), be purely registered-state-derived and not depend on s_valid or on a same-cycle pop.
REQ-005 A push and a pop in the same cycle SHALL leave the count unchanged, with the data order preserved.
REQ-006 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-007 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-008 IDLE->ISSUE SHALL occur when the FIFO is non-empty and m_valid=0, or when the FIFO is non-empty and m_valid=1 with m_ready=1 in the same cycle; otherwise the FSM SHALL stay in IDLE.
REQ-009 In ISSUE (exactly 1 cycle):
- fir_in_valid SHALL be 1.
- fir_in_data SHALL be the FIFO head.
- The head SHALL be popped.
- The FSM SHALL go to WAIT.
REQ-010 fir_in_data SHALL be registered and SHALL hold the last issued sample until the next ISSUE.
REQ-011 In WAIT:
- A wait counter SHALL start at 0 on entry and increment every cycle.
- busy SHALL be 1.
- fir_out_valid=1 SHALL load fir_out_data into the output register, set m_valid=1 on the next cycle, and send the FSM to IDLE.
REQ-012 If the wait counter reaches TIMEOUT-1 with no fir_out_valid, the block SHALL:
- set timeout_err;
- return to IDLE;
- produce no output;
- discard the sample.
REQ-013 If fir_out_valid and the timeout occur in the same cycle, the result SHALL win: the result is captured and timeout_err is not set.
REQ-014 fir_out_valid in IDLE or ISSUE SHALL be ignored, with no state or output change.
REQ-015 Downstream transfer SHALL occur when m_valid=1 and m_ready=1; m_valid SHALL then clear on the next edge unless a new result is captured on the same edge.
REQ-016 While m_valid=1 and m_ready=0, m_data SHALL remain stable.
REQ-017 At most one sample SHALL be in flight; a new ISSUE SHALL never occur while in WAIT.
REQ-018 timeout_err SHALL clear only on reset.
REQ-019 Issue latency SHALL be 2 edges: from a sample pushed into an empty FIFO in IDLE, fir_in_valid is asserted in the cycle after the next edge.

Reset
REQ-020 While rst=1, the block SHALL hold:
- FSM=IDLE;
- FIFO empty;
- fir_in_valid=0, fir_in_data=0;
- m_valid=0, m_data=0;
- busy=0, timeout_err=0;
- wait counter=0.
REQ-021 On rst deassertion, s_ready SHALL be 1.
REQ-022 Reset during WAIT SHALL abandon the in-flight sample; a later fir_out_valid SHALL then be ignored per REQ-014.

Verification
REQ-023 Single sample: push 0x0012, FIR model returns 0x000000ABCD 66 cycles after fir_in_valid -> exactly one fir_in_valid pulse with fir_in_data=0x0012; m_valid=1 with m_data=0xABCD one cycle after fir_out_valid.
REQ-024 Fill and backpressure: push 5 samples back-to-back with m_ready=0 and FIR responding -> s_ready=0 once 4 samples are buffered; only 1 sample is issued until m_ready=1; results emerge in push order.
REQ-025 Timeout: FIR never responds -> timeout_err=1 at WAIT cycle 99, FSM back in IDLE, the next queued sample is issued, no m_valid.
REQ-026 Race: fir_out_valid on wait cycle TIMEOUT-1 -> result captured, timeout_err stays 0.
REQ-027 Reset mid-WAIT: assert rst 10 cycles into WAIT, then a FIR pulse after release -> all outputs 0, no m_valid, s_ready=1.
REQ-028 Spurious pulse: fir_out_valid while IDLE with an empty FIFO -> no m_valid and no state change.
